// File: rtl/wb_cmd_master.sv
// Byte-stream command parser driving single classic Wishbone cycles; status/read data returned as bytes.
// Latency: last command byte to rsp_valid_o is 2 cycles with a zero-wait ack, plus one cycle per ack wait state.
// Backpressure: cmd_ready_o drops from the bus cycle until the last response byte is taken; responses hold until rsp_ready_i.
// Optional: define WB_CMD_MASTER_ERR_EN to add wbm_err_i (bus error terminates the cycle with a 0x15 response).
module wb_cmd_master #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TO_W           = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  cmd_byte_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    output logic [7:0]  rsp_byte_o,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_addr_o,
    output logic [31:0] wbm_wdata_o,
    output logic [3:0]  wbm_sel_o,
    input  logic [31:0] wbm_rdata_i,
    input  logic        wbm_ack_i,
`ifdef WB_CMD_MASTER_ERR_EN
    input  logic        wbm_err_i,
`endif
    output logic        busy_o
);

    localparam logic [7:0] OP_RD  = 8'h52;
    localparam logic [7:0] OP_WR  = 8'h57;
    localparam logic [7:0] RSP_OK = 8'h06;
    localparam logic [7:0] RSP_NG = 8'h15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WDATA,
        S_BUS,
        S_RSP_HDR,
        S_RSP_DATA
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            we_q;
    logic            rd_ok;
    logic            cyc_q;
    logic [1:0]      byte_cnt;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic [31:0]     rdata_q;
    logic [7:0]      rsp_q;
    logic [TO_W-1:0] to_cnt;
    logic            cmd_fire;
    logic            rsp_fire;
    logic            bus_err;
    logic            to_hit;
    logic            is_op;

`ifdef WB_CMD_MASTER_ERR_EN
    assign bus_err = wbm_err_i;
`else
    assign bus_err = 1'b0;
`endif

    assign cmd_fire = cmd_valid_i && cmd_ready_o;
    assign rsp_fire = rsp_valid_o && rsp_ready_i;
    assign is_op    = (cmd_byte_i == OP_RD) || (cmd_byte_i == OP_WR);
    // A zero TIMEOUT_CYCLES disables the watchdog entirely.
    assign to_hit   = (TIMEOUT_CYCLES != 0) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // cyc/stb/we/sel come straight from a flop so the bus never sees decode glitches.
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = cyc_q;
    assign wbm_we_o    = cyc_q && we_q;
    assign wbm_sel_o   = {4{cyc_q}};
    assign wbm_addr_o  = addr_q;
    assign wbm_wdata_o = wdata_q;
    assign rsp_byte_o  = rsp_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        state_nxt   = state;
        cmd_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        busy_o      = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_fire) begin
                    state_nxt = is_op ? S_ADDR : S_RSP_HDR;
                end
            end
            S_ADDR: begin
                cmd_ready_o = 1'b1;
                if (cmd_fire && (byte_cnt == 2'd3)) begin
                    state_nxt = we_q ? S_WDATA : S_BUS;
                end
            end
            S_WDATA: begin
                cmd_ready_o = 1'b1;
                if (cmd_fire && (byte_cnt == 2'd3)) begin
                    state_nxt = S_BUS;
                end
            end
            S_BUS: begin
                if (bus_err || wbm_ack_i || to_hit) begin
                    state_nxt = S_RSP_HDR;
                end
            end
            S_RSP_HDR: begin
                rsp_valid_o = 1'b1;
                if (rsp_fire) begin
                    state_nxt = rd_ok ? S_RSP_DATA : S_IDLE;
                end
            end
            S_RSP_DATA: begin
                rsp_valid_o = 1'b1;
                if (rsp_fire && (byte_cnt == 2'd3)) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Bus strobe flop: high exactly while the FSM sits in BUS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_q <= 1'b0;
        end else begin
            cyc_q <= (state_nxt == S_BUS);
        end
    end

    // Ack watchdog: restarts at zero on every BUS entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (state == S_BUS) begin
            to_cnt <= to_cnt + TO_W'(1);
        end else begin
            to_cnt <= '0;
        end
    end

    // Frame assembly, bus result capture and response byte sequencing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q     <= 1'b0;
            rd_ok    <= 1'b0;
            byte_cnt <= 2'd0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rsp_q    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_fire) begin
                        byte_cnt <= 2'd0;
                        rd_ok    <= 1'b0;
                        if (is_op) begin
                            we_q <= (cmd_byte_i == OP_WR);
                        end else begin
                            rsp_q <= RSP_NG;
                        end
                    end
                end
                S_ADDR: begin
                    if (cmd_fire) begin
                        addr_q   <= {addr_q[23:0], cmd_byte_i};
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                S_WDATA: begin
                    if (cmd_fire) begin
                        wdata_q  <= {wdata_q[23:0], cmd_byte_i};
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                S_BUS: begin
                    // Priority: error, then ack (even on the expiry cycle), then timeout.
                    if (bus_err) begin
                        rsp_q <= RSP_NG;
                        rd_ok <= 1'b0;
                    end else if (wbm_ack_i) begin
                        rsp_q <= RSP_OK;
                        rd_ok <= !we_q;
                        if (!we_q) begin
                            rdata_q <= wbm_rdata_i;
                        end
                    end else if (to_hit) begin
                        rsp_q <= RSP_NG;
                        rd_ok <= 1'b0;
                    end
                end
                S_RSP_HDR: begin
                    if (rsp_fire && rd_ok) begin
                        rsp_q    <= rdata_q[31:24];
                        rdata_q  <= {rdata_q[23:0], 8'h00};
                        byte_cnt <= 2'd0;
                    end
                end
                S_RSP_DATA: begin
                    if (rsp_fire) begin
                        rsp_q    <= rdata_q[31:24];
                        rdata_q  <= {rdata_q[23:0], 8'h00};
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Bench for wb_cmd_master: table of command frames with a scripted Wishbone slave and a response scoreboard.
// Latency from last command byte to first response byte is checked per vector.
// Response sink can toggle rsp_ready_i to exercise output stalls.
module tb_wb_cmd_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  cmd_byte = 8'h00;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  rsp_byte;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic        wbm_cyc, wbm_stb, wbm_we, wbm_ack;
    logic [31:0] wbm_addr, wbm_wdata;
    logic [3:0]  wbm_sel;
    logic [31:0] slave_rdata = 32'h0;
    logic        busy;

    bit ack_en = 1'b0;
    int ack_at = 0;
    bit err_en = 1'b0;
    int err_at = 0;
    bit tog    = 1'b0;
    int cyc_cnt = 0;

    int checks = 0;
    int failures = 0;

    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    // Scripted slave: ack/err in the cycle whose index (from 0) within the bus cycle matches.
    always @(posedge clk) cyc_cnt <= wbm_cyc ? cyc_cnt + 1 : 0;
    assign wbm_ack = wbm_cyc && wbm_stb && ack_en && (cyc_cnt == ack_at);

`ifdef WB_CMD_MASTER_ERR_EN
    logic wbm_err;
    assign wbm_err = wbm_cyc && wbm_stb && err_en && (cyc_cnt == err_at);
`endif

    wb_cmd_master #(.TIMEOUT_CYCLES(8), .TO_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_byte_i  (cmd_byte),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .rsp_byte_o  (rsp_byte),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .wbm_cyc_o   (wbm_cyc),
        .wbm_stb_o   (wbm_stb),
        .wbm_we_o    (wbm_we),
        .wbm_addr_o  (wbm_addr),
        .wbm_wdata_o (wbm_wdata),
        .wbm_sel_o   (wbm_sel),
        .wbm_rdata_i (slave_rdata),
        .wbm_ack_i   (wbm_ack),
`ifdef WB_CMD_MASTER_ERR_EN
        .wbm_err_i   (wbm_err),
`endif
        .busy_o      (busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Response sink: ready either stuck high or toggling each cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            rsp_ready = tog ? ~rsp_ready : 1'b1;
        end
    end

    // Bus observer and response scoreboard, sampled mid-cycle.
    int          txn_cnt = 0;
    int          stab_err = 0;
    int          cur_len = 0;
    int          last_len = 0;
    bit          in_cyc = 1'b0;
    logic [31:0] cap_addr, cap_wdata;
    logic        cap_we;
    logic [3:0]  cap_sel;
    bit          stalled = 1'b0;
    logic [7:0]  held;

    always @(negedge clk) begin
        if (wbm_cyc) begin
            if (!in_cyc) begin
                in_cyc    = 1'b1;
                cur_len   = 0;
                cap_addr  = wbm_addr;
                cap_wdata = wbm_wdata;
                cap_we    = wbm_we;
                cap_sel   = wbm_sel;
            end else if (wbm_addr !== cap_addr || wbm_wdata !== cap_wdata ||
                         wbm_we !== cap_we || wbm_sel !== cap_sel) begin
                stab_err++;
            end
            if (wbm_stb !== 1'b1) stab_err++;
            cur_len++;
        end else if (in_cyc) begin
            in_cyc   = 1'b0;
            last_len = cur_len;
            txn_cnt++;
        end
        if (rsp_valid) begin
            if (stalled) chk("rsp_hold", {56'h0, rsp_byte}, {56'h0, held});
            if (rsp_ready) begin
                stalled = 1'b0;
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", {56'h0, rsp_byte}, 64'hFFFF);
                end else begin
                    chk("rsp_byte", {56'h0, rsp_byte}, {56'h0, exp_q.pop_front()});
                end
            end else begin
                stalled = 1'b1;
                held    = rsp_byte;
            end
        end else begin
            stalled = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bit rdy;
        int n = 0;
        cmd_byte  = b;
        cmd_valid = 1'b1;
        forever begin
            rdy = cmd_ready;
            @(posedge clk);
            if (rdy) break;
            #1;
            n++;
            if (n > 200) begin
                chk("cmd_ready_wait", 0, 1);
                break;
            end
        end
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((exp_q.size() != 0 || busy) && n < 500);
        chk("idle_reached", {63'h0, (exp_q.size() == 0 && !busy)}, 1);
    endtask

    typedef struct {
        logic [71:0] frm;
        int          len;
        bit          ack_en;
        int          ack_at;
        bit          err_en;
        int          err_at;
        logic [31:0] rdata;
        logic [39:0] rsp;
        int          rsp_n;
        int          txns;
        int          cyc_len;
        logic [31:0] addr;
        bit          we;
        logic [31:0] wdata;
        int          lat;
        bit          tog;
    } vec_t;

    function automatic vec_t mk(input logic [71:0] frm, input int len, input bit a_en, input int a_at,
                                input bit e_en, input int e_at, input logic [31:0] rdata,
                                input logic [39:0] rsp, input int rsp_n, input int txns, input int cyc_len,
                                input logic [31:0] addr, input bit we, input logic [31:0] wdata,
                                input int lat, input bit tg);
        vec_t v;
        v.frm = frm; v.len = len; v.ack_en = a_en; v.ack_at = a_at; v.err_en = e_en; v.err_at = e_at;
        v.rdata = rdata; v.rsp = rsp; v.rsp_n = rsp_n; v.txns = txns; v.cyc_len = cyc_len;
        v.addr = addr; v.we = we; v.wdata = wdata; v.lat = lat; v.tog = tg;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        int t0 = txn_cnt;
        int s0 = stab_err;
        int lat = 0;
        ack_en = v.ack_en; ack_at = v.ack_at;
        err_en = v.err_en; err_at = v.err_at;
        slave_rdata = v.rdata;
        tog = v.tog;
        for (int i = 0; i < v.rsp_n; i++) exp_q.push_back(v.rsp[39 - 8*i -: 8]);
        for (int i = 0; i < v.len; i++) send_byte(v.frm[71 - 8*i -: 8]);
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 200);
        chk($sformatf("v%0d_latency", idx), lat, v.lat);
        wait_idle();
        tog = 1'b0;
        chk($sformatf("v%0d_txns", idx), txn_cnt - t0, v.txns);
        chk($sformatf("v%0d_stable", idx), stab_err - s0, 0);
        if (v.txns == 1) begin
            chk($sformatf("v%0d_cyc_len", idx), last_len, v.cyc_len);
            chk($sformatf("v%0d_addr", idx), cap_addr, v.addr);
            chk($sformatf("v%0d_we", idx), cap_we, v.we);
            chk($sformatf("v%0d_sel", idx), cap_sel, 4'hf);
            if (v.we) chk($sformatf("v%0d_wdata", idx), cap_wdata, v.wdata);
        end
        chk($sformatf("v%0d_cmd_ready", idx), cmd_ready, 1);
        ack_en = 1'b0; err_en = 1'b0;
    endtask

    vec_t vecs[$];

    initial begin
        vecs.push_back(mk({8'h57, 32'h10000004, 32'hDEADBEEF}, 9, 1, 2, 0, 0, 32'h0,
                          {8'h06, 32'h0}, 1, 1, 3, 32'h10000004, 1, 32'hDEADBEEF, 4, 0));
        vecs.push_back(mk({8'h52, 32'h20000000, 32'h0}, 5, 1, 0, 0, 0, 32'h12345678,
                          40'h06_12345678, 5, 1, 1, 32'h20000000, 0, 32'h0, 2, 1));
        vecs.push_back(mk({8'h52, 32'h30000008, 32'h0}, 5, 0, 0, 0, 0, 32'h0,
                          {8'h15, 32'h0}, 1, 1, 8, 32'h30000008, 0, 32'h0, 9, 0));
        vecs.push_back(mk({8'h52, 32'h3000000C, 32'h0}, 5, 1, 1, 0, 0, 32'hA5A55A5A,
                          40'h06_A5A55A5A, 5, 1, 2, 32'h3000000C, 0, 32'h0, 3, 1));
        vecs.push_back(mk({8'h41, 64'h0}, 1, 1, 0, 0, 0, 32'h0,
                          {8'h15, 32'h0}, 1, 0, 0, 32'h0, 0, 32'h0, 1, 0));
        vecs.push_back(mk({8'h52, 32'h00000040, 32'h0}, 5, 1, 0, 0, 0, 32'hCAFEF00D,
                          40'h06_CAFEF00D, 5, 1, 1, 32'h00000040, 0, 32'h0, 2, 0));
        vecs.push_back(mk({8'h57, 32'h00000100, 32'h11223344}, 9, 1, 7, 0, 0, 32'h0,
                          {8'h06, 32'h0}, 1, 1, 8, 32'h00000100, 1, 32'h11223344, 9, 0));
`ifdef WB_CMD_MASTER_ERR_EN
        vecs.push_back(mk({8'h57, 32'h00000200, 32'h55667788}, 9, 0, 0, 1, 1, 32'h0,
                          {8'h15, 32'h0}, 1, 1, 2, 32'h00000200, 1, 32'h55667788, 3, 0));
        vecs.push_back(mk({8'h52, 32'h00000300, 32'h0}, 5, 1, 0, 1, 0, 32'hFFFFFFFF,
                          {8'h15, 32'h0}, 1, 1, 1, 32'h00000300, 0, 32'h0, 2, 0));
`endif

        // Reset state while held in reset.
        repeat (3) @(negedge clk);
        chk("rst_cyc", wbm_cyc, 0);
        chk("rst_stb", wbm_stb, 0);
        chk("rst_we", wbm_we, 0);
        chk("rst_sel", wbm_sel, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addr", wbm_addr, 0);
        chk("rst_wdata", wbm_wdata, 0);
        chk("rst_rsp_byte", rsp_byte, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        // Reset in the middle of the address field: frame dropped, nothing answered.
        send_byte(8'h52);
        send_byte(8'h20);
        send_byte(8'h00);
        @(negedge clk);
        chk("mid_addr_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("mid_addr_busy_rst", busy, 0);
        chk("mid_addr_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid_addr_no_rsp", rsp_valid, 0);

        // Reset while the bus cycle is outstanding.
        ack_en = 1'b0;
        send_byte(8'h52);
        for (int i = 0; i < 4; i++) send_byte(8'h44);
        repeat (3) @(negedge clk);
        chk("mid_bus_cyc", wbm_cyc, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_bus_cyc_rst", wbm_cyc, 0);
        chk("mid_bus_stb_rst", wbm_stb, 0);
        chk("mid_bus_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("mid_bus_no_rsp", rsp_valid, 0);
        chk("mid_bus_no_cyc", wbm_cyc, 0);

        // Full frame after the reset recovers normally.
        run_vec(vecs[1], 99);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/wb_cmd_master.md
Name: wb_cmd_master

Overview:
Byte-stream-to-Wishbone initiator that lets a host-side serial link (UART or testio byte pipe) drive bus transactions into the SoC.
- Parses command frames from a valid/ready byte input.
- Issues single classic Wishbone read/write cycles as bus master, filling a crossbar master port.
- Returns status and read data as a valid/ready byte stream.

Parameters:
TIMEOUT_CYCLES, 1024, max cycles waiting for ack before abort; 0 = no timeout
TO_W, 16, width of timeout counter; TIMEOUT_CYCLES must be < 2**TO_W

Ports:
clk  input  1  single clock
rst  input  1  asynchronous, active-high reset
cmd_byte_i  input  8  command byte
cmd_valid_i  input  1  command byte valid
cmd_ready_o  output  1  block accepts command byte
rsp_byte_o  output  8  response byte
rsp_valid_o  output  1  response byte valid
rsp_ready_i  input  1  sink accepts response byte
wbm_cyc_o  output  1  Wishbone cycle
wbm_stb_o  output  1  Wishbone strobe
wbm_we_o  output  1  1 = write
wbm_addr_o  output  32  byte address
wbm_wdata_o  output  32  write data
wbm_sel_o  output  4  byte selects, always 4'hf during a cycle
wbm_rdata_i  input  32  read data
wbm_ack_i  input  1  slave acknowledge
busy_o  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst=1): state IDLE; cmd_ready_o=1 after release; all other outputs 0; wbm_addr_o, wbm_wdata_o, rsp_byte_o = 0; counters cleared.
- A partial frame or in-flight bus cycle at reset is discarded. No response is sent for it.
- Byte transfer occurs on posedge when valid&&ready. This holds for both streams.
- Frame format, all fields MSB-first:
  - Read: 0x52 ('R'), A3, A2, A1, A0.
  - Write: 0x57 ('W'), A3..A0, D3..D0.
- Responses:
  - Read OK: 0x06, D3..D0.
  - Write OK: 0x06.
  - Failure: 0x15.
- States:
  - IDLE: cmd_ready_o=1. Opcode 'R'/'W' latches we, clears 2-bit byte_cnt, goes to ADDR. Any other byte loads 0x15, goes to RSP_HDR; no bus cycle.
  - ADDR: cmd_ready_o=1. Shifts 4 bytes into addr register. After 4th byte: write goes to WDATA, read goes to BUS.
  - WDATA: cmd_ready_o=1. Shifts 4 bytes into wdata register. After 4th byte goes to BUS.
  - BUS: cmd_ready_o=0. wbm_cyc_o=wbm_stb_o=1 from the cycle after the final byte is accepted. wbm_addr_o, wbm_we_o, wbm_wdata_o, wbm_sel_o are stable throughout.
    - On posedge with wbm_ack_i=1: capture wbm_rdata_i (reads), drop cyc/stb on that same edge (registered outputs), load 0x06, go to RSP_HDR. One ack = exactly one transaction.
    - Timeout counter starts at 0 on BUS entry and increments each BUS cycle. If it reaches TIMEOUT_CYCLES-1 with no ack: drop cyc/stb, load 0x15, go to RSP_HDR.
    - Ack in the expiry cycle wins: success response.
  - RSP_HDR: rsp_valid_o=1, rsp_byte_o held stable until accepted. After acceptance:
    - Successful read goes to RSP_DATA with byte_cnt=0.
    - Otherwise goes to IDLE.
  - RSP_DATA: emits captured read data D3, D2, D1, D0, each held until accepted. After D0 goes to IDLE.
- cmd_ready_o=0 in BUS, RSP_HDR, RSP_DATA. Input back-pressure is the only flow control; no command buffering.
- Minimum latency, last command byte accepted to rsp_valid_o, with zero-wait ack (ack asserted combinationally on stb): 2 cycles (cyc/stb asserted cycle +1, RSP_HDR cycle +2).
- wbm_ack_i outside BUS is ignored.
- rsp_ready_i high while rsp_valid_o=0 has no effect.

Optional Feature:
WB_CMD_MASTER_ERR_EN
- Defined: adds input port wbm_err_i (1 bit). In BUS, err terminates the cycle like ack but responds 0x15; read data is not captured.
- Simultaneous ack and err: err wins.
- Not defined: no wbm_err_i port; only ack or timeout terminate.

Test Plan:
- Write: bytes 57 10 00 00 04 DE AD BE EF, slave acks after 3 cycles -> single cycle with we=1, addr=0x10000004, wdata=0xDEADBEEF, sel=f; cyc high exactly 3 cycles; response 06; cmd_ready_o returns 1.
- Read: bytes 52 20 00 00 00, slave returns 0x12345678 with zero-wait ack -> rsp_valid_o 2 cycles after last byte; response 06 12 34 56 78; rsp_ready_i toggled 1/0 -> each byte held stable while stalled.
- Timeout: TIMEOUT_CYCLES=8, read with no ack -> cyc/stb high exactly 8 cycles then low; response 15; next command then succeeds.
- Bad opcode 0x41 -> response 15, cyc never asserted; following 'R' frame processed normally.
- Async reset asserted mid-ADDR (after 2 address bytes) and mid-BUS -> cyc/stb/rsp_valid_o low immediately; no response byte emitted; subsequent full frame succeeds.
- With WB_CMD_MASTER_ERR_EN: write with err on cycle 2 -> response 15; ack and err together -> 15.
